// File: rtl/jtframe_ram_arb_if.sv
// Bus bundle for jtframe_ram_arb: three requester ports, the shared read
// data/strobes, and one port of a dual-port RAM with a one-cycle registered
// read.
//
// Handshake: a requester raises req[i] (with we[i], addr_i, din_i) and must
// hold all of them until it sees ack[i] high for one cycle; ack[i] marks the
// cycle the access is presented to the RAM. For reads, dok[i] pulses two
// cycles after ack[i] and dout is valid in that same cycle. A request
// dropped before the arbiter samples it in IDLE is simply never served.
interface jtframe_ram_arb_if #(
  parameter int DW = 8,
  parameter int AW = 10
);
  logic [2:0]    req;
  logic [2:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [2:0]    ack;
  logic [2:0]    dok;
  logic [DW-1:0] dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  // Requesters plus the RAM model: everything outside the arbiter.
  modport master (
    output req, we, addr0, addr1, addr2, din0, din1, din2, ram_q,
    input  ack, dok, dout, ram_addr, ram_din, ram_we
  );

  // The arbiter itself.
  modport slave (
    input  req, we, addr0, addr1, addr2, din0, din1, din2, ram_q,
    output ack, dok, dout, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/jtframe_ram_arb.sv
// jtframe_ram_arb: three-requester arbiter in front of one port of a
// dual-port RAM with a one-cycle registered read.
//
// One access at a time: IDLE -> ISSUE (ack, RAM write strobe) -> IDLE for
// writes, IDLE -> ISSUE -> WAIT (capture ram_q) -> DONE (dok) -> IDLE for
// reads. Requests that show up while an access is in flight are only seen
// in the next IDLE cycle.
//
// Build option: define JTFRAME_RAM_ARB_FIXPRIO_EN for fixed priority
// 0 > 1 > 2. Left undefined, arbitration is round-robin starting after the
// last granted requester (requester 0 first out of reset).
module jtframe_ram_arb #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jtframe_ram_arb_if.slave       bus,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [1:0]    win_q;
  logic [2:0]    ack_q;
  logic [2:0]    dok_q;
  logic [DW-1:0] dout_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;
  logic          ram_we_q;

  logic          any_req;
  logic          found;
  logic [1:0]    win_d;
  logic [AW-1:0] addr_win_d;
  logic [DW-1:0] din_win_d;
  logic          we_win_d;

`ifndef JTFRAME_RAM_ARB_FIXPRIO_EN
  logic [1:0]    last_grant_q;
  logic [1:0]    cand;

  // Successor in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] next3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction
`endif

  assign any_req = |bus.req;

  // Pick the winner among the requests visible this cycle.
  always_comb begin
    win_d = 2'd0;
    found = 1'b0;
`ifdef JTFRAME_RAM_ARB_FIXPRIO_EN
    for (int k = 0; k < 3; k++) begin
      if (!found && bus.req[k]) begin
        win_d = 2'(k);
        found = 1'b1;
      end
    end
`else
    cand = next3(last_grant_q);
    for (int k = 0; k < 3; k++) begin
      if (!found && bus.req[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
      cand = next3(cand);
    end
`endif
  end

  // Route the winner's address, data and direction to the RAM registers.
  always_comb begin
    addr_win_d = bus.addr0;
    din_win_d  = bus.din0;
    we_win_d   = bus.we[0];
    case (win_d)
      2'd1: begin
        addr_win_d = bus.addr1;
        din_win_d  = bus.din1;
        we_win_d   = bus.we[1];
      end
      2'd2: begin
        addr_win_d = bus.addr2;
        din_win_d  = bus.din2;
        we_win_d   = bus.we[2];
      end
      default: begin
        addr_win_d = bus.addr0;
        din_win_d  = bus.din0;
        we_win_d   = bus.we[0];
      end
    endcase
  end

  // Access sequencer: all outputs are registered here; ack/dok are
  // single-cycle pulses, so they default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= 2'd0;
      ack_q      <= 3'b000;
      dok_q      <= 3'b000;
      dout_q     <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      ack_q <= 3'b000;
      dok_q <= 3'b000;
      case (state_q)
        IDLE: begin
          ram_we_q <= 1'b0;
          if (any_req) begin
            win_q      <= win_d;
            ram_addr_q <= addr_win_d;
            ram_din_q  <= din_win_d;
            ram_we_q   <= we_win_d;
            ack_q      <= 3'b001 << win_d;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // ram_we_q doubles as the "this access is a write" flag.
          ram_we_q <= 1'b0;
          state_q  <= ram_we_q ? IDLE : WAIT;
        end
        WAIT: begin
          dout_q  <= bus.ram_q;
          dok_q   <= 3'b001 << win_q;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifndef JTFRAME_RAM_ARB_FIXPRIO_EN
  // Remember the most recent grant so the search starts just after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 2'd2;
    end else if (state_q == IDLE && any_req) begin
      last_grant_q <= win_d;
    end
  end
`endif

  assign bus.ack      = ack_q;
  assign bus.dok      = dok_q;
  assign bus.dout     = dout_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_we   = ram_we_q;
  assign state_o      = state_q;

  // Strobes are one-hot-or-idle; dout only moves when leaving WAIT.
  a_ack_1hot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ack_q));
  a_dok_1hot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(dok_q));
  a_dout_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != WAIT) |=> $stable(dout_q));

endmodule

// File: tb/tb_jtframe_ram_arb.sv
// Directed bench for jtframe_ram_arb with a behavioural dual-port RAM.
module tb_jtframe_ram_arb;

  localparam int DW = 8;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [1:0] state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jtframe_ram_arb_if #(.DW(DW), .AW(AW)) bus ();

  jtframe_ram_arb #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  // RAM with one-cycle registered read; pl_* is a bench-side preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_q <= mem[bus.ram_addr];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] rr_data(input logic [2:0] d);
    case (d)
      3'b001:  return 8'h11;
      3'b010:  return 8'h22;
      default: return 8'h33;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] a;
    logic [2:0] d;
    logic [2:0] e;
    logic [2:0] g;

    rst_n = 1'b0;
    bus.req = 3'b000; bus.we = 3'b000;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_ack", bus.ack, 0);
    check_eq("rst_dok", bus.dok, 0);
    check_eq("rst_dout", bus.dout, 0);
    check_eq("rst_we", bus.ram_we, 0);
    check_eq("rst_addr", bus.ram_addr, 0);
    check_eq("rst_din", bus.ram_din, 0);
    check_eq("rst_state", state, 0);

    preload(10'h010, 8'h11);
    preload(10'h020, 8'h22);
    preload(10'h030, 8'h33);
    preload(10'h040, 8'h5C);
    rst_n = 1'b1;
    tick();

    // Single write from requester 0
    bus.req = 3'b001; bus.we = 3'b001; bus.addr0 = 10'h005; bus.din0 = 8'hA5;
    tick();
    check_eq("wr_ack", bus.ack, 3'b001);
    check_eq("wr_we", bus.ram_we, 1);
    check_eq("wr_addr", bus.ram_addr, 10'h005);
    check_eq("wr_din", bus.ram_din, 8'hA5);
    check_eq("wr_state", state, 1);
    bus.req = 3'b000; bus.we = 3'b000;
    tick();
    check_eq("wr_ack_off", bus.ack, 0);
    check_eq("wr_we_off", bus.ram_we, 0);
    check_eq("wr_idle", state, 0);
    check_eq("wr_mem", mem[10'h005], 8'hA5);

    // Single read from requester 1
    bus.req = 3'b010; bus.addr1 = 10'h005;
    tick();
    check_eq("rd_ack", bus.ack, 3'b010);
    check_eq("rd_we", bus.ram_we, 0);
    bus.req = 3'b000;
    tick();
    check_eq("rd_wait_dok", bus.dok, 0);
    check_eq("rd_wait_state", state, 2);
    tick();
    check_eq("rd_dok", bus.dok, 3'b010);
    check_eq("rd_dout", bus.dout, 8'hA5);
    check_eq("rd_done_ack", bus.ack, 0);
    tick();
    check_eq("rd_dok_off", bus.dok, 0);
    check_eq("rd_dout_hold", bus.dout, 8'hA5);
    check_eq("rd_idle", state, 0);

    // Arbitration with all three reading continuously, from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`ifdef JTFRAME_RAM_ARB_FIXPRIO_EN
    exp_q = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    bus.addr0 = 10'h010; bus.addr1 = 10'h020; bus.addr2 = 10'h030;
    bus.we = 3'b000; bus.req = 3'b111;
    for (int i = 1; i <= 18; i++) begin
      tick();
      a = bus.ack;
      d = bus.dok;
      if (a != 3'b000) got_q.push_back(a);
      check_eq("rr_ack_1hot", {31'b0, $onehot0(a)}, 1);
      check_eq("rr_dok_1hot", {31'b0, $onehot0(d)}, 1);
      check_eq("rr_no_overlap", {31'b0, (a != 0) && (d != 0)}, 0);
      if (d != 3'b000) check_eq("rr_dout", bus.dout, rr_data(d));
      if (i == 14) bus.req = 3'b000;
    end
    check_eq("rr_grants", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 3'b000;
      check_eq("rr_order", g, e);
    end

    // Contention: requester 2 arrives while requester 0's read is in WAIT
    bus.req = 3'b001; bus.addr0 = 10'h010;
    tick();
    check_eq("ct_ack0", bus.ack, 3'b001);
    bus.req = 3'b000;
    tick();
    check_eq("ct_wait", state, 2);
    bus.req = 3'b100; bus.addr2 = 10'h030;
    tick();
    check_eq("ct_dok0", bus.dok, 3'b001);
    check_eq("ct_no_ack_done", bus.ack, 0);
    check_eq("ct_dout0", bus.dout, 8'h11);
    tick();
    check_eq("ct_no_ack_idle", bus.ack, 0);
    tick();
    check_eq("ct_ack2", bus.ack, 3'b100);
    bus.req = 3'b000;
    tick();
    tick();
    check_eq("ct_dok2", bus.dok, 3'b100);
    check_eq("ct_dout2", bus.dout, 8'h33);
    tick();

    // Reset in the ISSUE cycle of a write
    bus.req = 3'b001; bus.we = 3'b001; bus.addr0 = 10'h040; bus.din0 = 8'hFF;
    tick();
    check_eq("ar_we_issue", bus.ram_we, 1);
    #3;
    rst_n = 1'b0;
    bus.req = 3'b000; bus.we = 3'b000;
    #1;
    check_eq("ar_we_drop", bus.ram_we, 0);
    check_eq("ar_ack_drop", bus.ack, 0);
    check_eq("ar_state", state, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("ar_quiet", {26'b0, bus.ack, bus.dok}, 0);
    end
    check_eq("ar_mem", mem[10'h040], 8'h5C);

    // Withdrawn request: requester 1 pulses while the FSM is busy
    bus.req = 3'b001; bus.addr0 = 10'h010;
    tick();
    check_eq("wd_ack0", bus.ack, 3'b001);
    bus.req = 3'b000;
    tick();
    bus.req = 3'b010; bus.addr1 = 10'h050;
    tick();
    check_eq("wd_dok0", bus.dok, 3'b001);
    bus.req = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("wd_no_ack", bus.ack, 0);
    end
    check_eq("wd_addr", bus.ram_addr, 10'h010);
    check_eq("wd_idle", state, 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
